// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter. It handles one digit per clock,
// most significant digit first, using a multiply-by-10 accumulate.
module bcd_to_binary_seq #(
   parameter int DIGITS = 5,
   parameter int BIN_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err_digit,
   output logic                  overflow
);

   localparam int ACC_W = BIN_W + 4;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [ACC_W-1:0] BIN_MAX  = {4'b0000, {BIN_W{1'b1}}};
   localparam logic [ACC_W-1:0] ACC_CLMP = BIN_MAX + 1'b1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state;
   logic [ACC_W-1:0]    acc;
   logic [4*DIGITS-1:0] shreg;
   logic [CNT_W-1:0]    cnt;
   logic                err_s;
   logic                ovf_s;

   logic [3:0]          digit;
   logic [ACC_W-1:0]    acc_sum;
   logic [ACC_W-1:0]    acc_next;
   logic                err_next;
   logic                ovf_next;

   // Once overflow is seen the accumulator parks at 2^BIN_W, so acc*10+15 always fits.
   always_comb begin
      digit    = shreg[4*DIGITS-1 -: 4];
      acc_sum  = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
      err_next = err_s | (digit > 4'd9);
      ovf_next = ovf_s | (acc_sum > BIN_MAX);
      acc_next = ovf_next ? ACC_CLMP : acc_sum;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc       <= '0;
         shreg     <= '0;
         cnt       <= '0;
         err_s     <= 1'b0;
         ovf_s     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bin_out   <= '0;
         err_digit <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= bcd_in;
                  acc   <= '0;
                  err_s <= 1'b0;
                  ovf_s <= 1'b0;
                  cnt   <= LAST_CNT;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               acc   <= acc_next;
               shreg <= shreg << 4;
               cnt   <= cnt - 1'b1;
               err_s <= err_next;
               ovf_s <= ovf_next;
               if (cnt == '0) begin
                  // An invalid digit outranks overflow when the result is committed.
                  if (err_next) begin
                     bin_out   <= '0;
                     err_digit <= 1'b1;
                     overflow  <= 1'b0;
                  end else if (ovf_next) begin
                     bin_out   <= '1;
                     err_digit <= 1'b0;
                     overflow  <= 1'b1;
                  end else begin
                     bin_out   <= acc_next[BIN_W-1:0];
                     err_digit <= 1'b0;
                     overflow  <= 1'b0;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: a table of directed conversions
// followed by hand-written handshake, reset and hold sequences.
module tb_bcd_to_binary_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [19:0] bcd_in;
   logic        busy;
   logic        done;
   logic [15:0] bin_out;
   logic        err_digit;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [19:0] bcd;
      logic [15:0] bin;
      logic        err;
      logic        ovf;
   } vec_t;

   vec_t vecs[9];

   bcd_to_binary_seq #(.DIGITS(5), .BIN_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bcd_in    (bcd_in),
      .busy      (busy),
      .done      (done),
      .bin_out   (bin_out),
      .err_digit (err_digit),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse start with the given word, then wait (bounded) for done.
   // lat is the number of edges after the accept edge at which done was seen, -1 on timeout.
   task automatic apply_stimulus(input logic [19:0] bcd, output int lat, output bit busy_gap);
      @(negedge clk);
      bcd_in = bcd;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat      = -1;
      busy_gap = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) busy_gap = 1'b1;
      end
   endtask

   task automatic check_output(input string name, input logic [15:0] exp_bin,
                               input logic exp_err, input logic exp_ovf,
                               input int lat, input bit busy_gap);
      check({name, " latency"}, lat, 5);
      check({name, " busy_gap"}, {31'd0, busy_gap}, 32'd0);
      check({name, " bin_out"}, {16'd0, bin_out}, {16'd0, exp_bin});
      check({name, " flags"}, {30'd0, err_digit, overflow}, {30'd0, exp_err, exp_ovf});
      check({name, " busy_with_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int  lat;
      bit  gap;
      int  done_cnt;

      vecs[0] = '{"nominal",  20'h48879, 16'hBEEF, 1'b0, 1'b0};
      vecs[1] = '{"max",      20'h65535, 16'hFFFF, 1'b0, 1'b0};
      vecs[2] = '{"zero",     20'h00000, 16'h0000, 1'b0, 1'b0};
      vecs[3] = '{"max_p1",   20'h65536, 16'hFFFF, 1'b0, 1'b1};
      vecs[4] = '{"all9",     20'h99999, 16'hFFFF, 1'b0, 1'b1};
      vecs[5] = '{"bad_dig",  20'h1A234, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{"after_err",20'h00042, 16'h002A, 1'b0, 1'b0};
      vecs[7] = '{"n9999",    20'h09999, 16'h270F, 1'b0, 1'b0};
      vecs[8] = '{"err_ovf",  20'h9F999, 16'h0000, 1'b1, 1'b0};

      reset  = 1'b0;
      start  = 1'b0;
      bcd_in = 20'h00000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {27'd0, busy, done, err_digit, overflow, 1'b0, bin_out},
            32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].bcd, lat, gap);
         check_output(vecs[i].name, vecs[i].bin, vecs[i].err, vecs[i].ovf, lat, gap);
      end

      // Start pulsed while busy, with bcd_in changed, must be ignored entirely.
      @(negedge clk);
      bcd_in = 20'h01234;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bcd_in = 20'h09999;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      check("busy_start done_count", done_cnt, 1);
      check("busy_start bin_out", {16'd0, bin_out}, 32'h04D2);
      check("busy_start idle", {31'd0, busy}, 32'd0);

      // Back-to-back: a new start issued in the done cycle.
      apply_stimulus(20'h00456, lat, gap);
      check_output("b2b_first", 16'h01C8, 1'b0, 1'b0, lat, gap);
      check("b2b done_cycle", {31'd0, done}, 32'd1);
      start  = 1'b1;
      bcd_in = 20'h00007;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b accepted", {30'd0, busy, done}, 32'd2);
      check("b2b held_result", {16'd0, bin_out}, 32'h01C8);
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check("b2b latency", lat, 5);
      check("b2b bin_out", {16'd0, bin_out}, 32'h0007);

      // Start held high across the commit edge must not launch a conversion.
      @(negedge clk);
      bcd_in = 20'h00033;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start  = 1'b1;
      bcd_in = 20'h00099;
      @(posedge clk);
      #1 start = 1'b0;
      check("commit_start done", {15'd0, done, bin_out}, {15'd0, 1'b1, 16'h0021});
      @(posedge clk);
      #1;
      check("commit_start ignored", {30'd0, busy, done}, 32'd0);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      bcd_in = 20'h12345;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset outputs", {28'd0, busy, done, err_digit, overflow},
            32'd0);
      check("midreset bin_out", {16'd0, bin_out}, 32'd0);
      done_cnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_cnt++;
      end
      check("midreset quiet", done_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      apply_stimulus(20'h00100, lat, gap);
      check_output("post_reset", 16'h0064, 1'b0, 1'b0, lat, gap);

      // Results hold while bcd_in wanders and start stays low.
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         bcd_in = 20'($urandom);
         @(posedge clk);
         #1;
         check("hold", {13'd0, done, err_digit, overflow, bin_out}, 32'h0064);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
